microwave_ctrl_gen: RTL and testbench

Parametrised next-generation microwave controller. It combines keypad time entry, a BCD countdown timer, start/stop/clear/door control and magnetron drive in one synchronous block. New over the current controller: an internal 1 Hz prescaler, configurable minute-digit count, selectable power level with duty-cycled magnetron drive, pause/resume, and an end-of-cook done indication. It sits between the keypad/button front end and the seg7 display driver.

---
 rtl/microwave_ctrl_gen.sv | 198 +++++++++++++++++++
 tb/tb_microwave_ctrl_gen.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/microwave_ctrl_gen.sv
// Microwave controller: keypad time entry, BCD countdown with internal 1 s
// prescaler, power-level duty cycling of the magnetron, pause/resume and a
// timed end-of-cook indication. All outputs come straight from flops.
module microwave_ctrl_gen #(
    parameter int unsigned TICK_DIV   = 50_000_000,
    parameter int unsigned MIN_DIGITS = 1,
    parameter int unsigned DONE_TICKS = 3
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic [9:0]              keypad,
    input  logic                    powern,
    input  logic                    startn,
    input  logic                    stopn,
    input  logic                    clearn,
    input  logic                    door_closed,
    output logic [3:0]              sec_ones,
    output logic [3:0]              sec_tens,
    output logic [4*MIN_DIGITS-1:0] minutes,
    output logic [3:0]              power_level,
    output logic                    mag_on,
    output logic                    cooking,
    output logic                    done
);

    localparam int unsigned PW = $clog2(TICK_DIV);
    localparam int unsigned DW = (DONE_TICKS > 1) ? $clog2(DONE_TICKS) : 1;
    localparam int unsigned ND = MIN_DIGITS + 2;
    localparam int unsigned TW = 4 * ND;

    typedef enum logic [1:0] {S_IDLE, S_COOK, S_PAUSE, S_DONE} state_e;

    state_e          state_q, state_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic [3:0]      phase_q, phase_d;
    logic            armed_q, armed_d;
    logic [3:0]      power_q, power_d;
    logic [TW-1:0]   time_q, time_d;      // {minutes, tens, ones}
    logic [DW-1:0]   done_cnt_q, done_cnt_d;
    logic            mag_on_q, mag_on_d;
    logic            cooking_q, cooking_d;
    logic            done_q, done_d;
    logic [9:0]      key_prev_q, key_prev_d;
    logic            powern_prev_q, powern_prev_d;
    logic            startn_prev_q, startn_prev_d;
    logic            stopn_prev_q, stopn_prev_d;

    logic [9:0]      key_rise;
    logic            key_valid;
    logic [3:0]      key_digit;
    logic            power_e, start_e, stop_e;
    logic            running, tick;
    logic            time_zero, dec_zero, borrow;
    logic [TW-1:0]   time_dec;

    // Edge detection, single-key decode and tick generation
    always_comb begin
        key_rise  = keypad & ~key_prev_q;
        key_valid = $onehot(key_rise);
        key_digit = '0;
        for (int unsigned i = 0; i < 10; i++) begin
            if (key_rise[i]) key_digit = 4'(i);
        end
        power_e   = powern_prev_q & ~powern;
        start_e   = startn_prev_q & ~startn;
        stop_e    = stopn_prev_q & ~stopn;
        running   = (state_q == S_COOK) || (state_q == S_DONE);
        tick      = running && (presc_q == PW'(TICK_DIV - 1));
        time_zero = (time_q == '0);
    end

    // One-second BCD decrement: borrow ripples up, tens wraps to 5, others to 9
    always_comb begin
        time_dec = time_q;
        borrow   = 1'b1;
        for (int unsigned i = 0; i < ND; i++) begin
            if (borrow) begin
                if (time_q[4*i +: 4] == 4'd0) begin
                    time_dec[4*i +: 4] = (i == 1) ? 4'd5 : 4'd9;
                end else begin
                    time_dec[4*i +: 4] = time_q[4*i +: 4] - 4'd1;
                    borrow             = 1'b0;
                end
            end
        end
        dec_zero = (time_dec == '0);
    end

    // Next state: one event per cycle, taken in fixed priority order
    always_comb begin
        state_d       = state_q;
        presc_d       = presc_q;
        phase_d       = phase_q;
        armed_d       = armed_q;
        power_d       = power_q;
        time_d        = time_q;
        done_cnt_d    = done_cnt_q;
        key_prev_d    = keypad;
        powern_prev_d = powern;
        startn_prev_d = startn;
        stopn_prev_d  = stopn;

        if (running) presc_d = tick ? '0 : presc_q + PW'(1);

        if (!clearn) begin
            time_d  = '0;
            power_d = 4'd10;
            armed_d = 1'b0;
            state_d = S_IDLE;
        end else if ((state_q == S_COOK) && !door_closed) begin
            state_d = S_PAUSE;
        end else if (stop_e) begin
            if (state_q == S_COOK) begin
                state_d = S_PAUSE;
            end else begin
                time_d  = '0;
                state_d = S_IDLE;
            end
        end else if (tick) begin
            if (state_q == S_COOK) begin
                time_d  = time_dec;
                phase_d = (phase_q == 4'd9) ? 4'd0 : phase_q + 4'd1;
                if (dec_zero) begin
                    state_d    = S_DONE;
                    done_cnt_d = '0;
                end
            end else if (done_cnt_q == DW'(DONE_TICKS - 1)) begin
                state_d = S_IDLE;
            end else begin
                done_cnt_d = done_cnt_q + DW'(1);
            end
        end else if (start_e) begin
            if (((state_q == S_IDLE) || (state_q == S_PAUSE)) && door_closed && !time_zero) begin
                state_d = S_COOK;
                presc_d = '0;
                phase_d = '0;
            end
        end else if (power_e) begin
            if (state_q == S_IDLE) armed_d = 1'b1;
        end else if (key_valid && ((state_q == S_IDLE) || (state_q == S_DONE))) begin
            state_d = S_IDLE;
            if (armed_q) begin
                power_d = (key_digit == 4'd0) ? 4'd10 : key_digit;
                armed_d = 1'b0;
            end else begin
                time_d = {time_q[TW-5:0], key_digit};
            end
        end

        cooking_d = (state_d == S_COOK);
        done_d    = (state_d == S_DONE);
        mag_on_d  = cooking_d && door_closed && (phase_d < power_d);
    end

    // State and output registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q       <= S_IDLE;
            presc_q       <= '0;
            phase_q       <= '0;
            armed_q       <= 1'b0;
            power_q       <= 4'd10;
            time_q        <= '0;
            done_cnt_q    <= '0;
            mag_on_q      <= 1'b0;
            cooking_q     <= 1'b0;
            done_q        <= 1'b0;
            key_prev_q    <= '0;
            powern_prev_q <= 1'b1;
            startn_prev_q <= 1'b1;
            stopn_prev_q  <= 1'b1;
        end else begin
            state_q       <= state_d;
            presc_q       <= presc_d;
            phase_q       <= phase_d;
            armed_q       <= armed_d;
            power_q       <= power_d;
            time_q        <= time_d;
            done_cnt_q    <= done_cnt_d;
            mag_on_q      <= mag_on_d;
            cooking_q     <= cooking_d;
            done_q        <= done_d;
            key_prev_q    <= key_prev_d;
            powern_prev_q <= powern_prev_d;
            startn_prev_q <= startn_prev_d;
            stopn_prev_q  <= stopn_prev_d;
        end
    end

    assign sec_ones    = time_q[3:0];
    assign sec_tens    = time_q[7:4];
    assign minutes     = time_q[TW-1:8];
    assign power_level = power_q;
    assign mag_on      = mag_on_q;
    assign cooking     = cooking_q;
    assign done        = done_q;

endmodule

// File: tb/tb_microwave_ctrl_gen.sv
// Bench for microwave_ctrl_gen: one-digit and two-digit-minute instances
// share stimulus; a seconds-arithmetic reference model predicts every output.
module tb_microwave_ctrl_gen;

    localparam int TD = 4;

    logic       clk = 1'b0;
    logic       rstn, powern, startn, stopn, clearn, door_closed;
    logic [9:0] keypad;

    logic [3:0] a_ones, a_tens, a_min, a_pwr;
    logic       a_mag, a_cook, a_done;
    logic [3:0] b_ones, b_tens, b_pwr;
    logic [7:0] b_min;
    logic       b_mag, b_cook, b_done;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model state: time kept as a decimal number mmss
    int m_v[2], m_pwr[2], m_presc[2], m_phase[2], m_left[2];
    bit m_armed[2], m_cook[2], m_pause[2], m_done[2], m_mag[2];
    logic [9:0] p_key;
    logic       p_powern, p_startn, p_stopn;

    always #5 clk = ~clk;

    microwave_ctrl_gen #(.TICK_DIV(TD), .MIN_DIGITS(1), .DONE_TICKS(3)) dut_a (
        .clk(clk), .rstn(rstn), .keypad(keypad), .powern(powern), .startn(startn),
        .stopn(stopn), .clearn(clearn), .door_closed(door_closed),
        .sec_ones(a_ones), .sec_tens(a_tens), .minutes(a_min), .power_level(a_pwr),
        .mag_on(a_mag), .cooking(a_cook), .done(a_done));

    microwave_ctrl_gen #(.TICK_DIV(TD), .MIN_DIGITS(2), .DONE_TICKS(3)) dut_b (
        .clk(clk), .rstn(rstn), .keypad(keypad), .powern(powern), .startn(startn),
        .stopn(stopn), .clearn(clearn), .door_closed(door_closed),
        .sec_ones(b_ones), .sec_tens(b_tens), .minutes(b_min), .power_level(b_pwr),
        .mag_on(b_mag), .cooking(b_cook), .done(b_done));

    function automatic int to_bcd(input int m);
        return (m / 10) * 16 + (m % 10);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic model_step();
        logic [9:0] rise;
        bit se, te, pe, ke, tick;
        int d, modv;
        if (!rstn) begin
            for (int k = 0; k < 2; k++) begin
                m_v[k] = 0; m_pwr[k] = 10; m_presc[k] = 0; m_phase[k] = 0; m_left[k] = 0;
                m_armed[k] = 0; m_cook[k] = 0; m_pause[k] = 0; m_done[k] = 0; m_mag[k] = 0;
            end
            p_key = '0; p_powern = 1'b1; p_startn = 1'b1; p_stopn = 1'b1;
            return;
        end
        rise = keypad & ~p_key;
        ke = ($countones(rise) == 1);
        d = 0;
        for (int i = 0; i < 10; i++) if (rise[i]) d = i;
        se = p_startn && !startn;
        te = p_stopn && !stopn;
        pe = p_powern && !powern;
        for (int k = 0; k < 2; k++) begin
            modv = (k == 0) ? 1000 : 10000;
            tick = (m_cook[k] || m_done[k]) && (m_presc[k] == TD - 1);
            if (m_cook[k] || m_done[k]) m_presc[k] = tick ? 0 : m_presc[k] + 1;
            if (!clearn) begin
                m_v[k] = 0; m_pwr[k] = 10; m_armed[k] = 0;
                m_cook[k] = 0; m_pause[k] = 0; m_done[k] = 0;
            end else if (m_cook[k] && !door_closed) begin
                m_cook[k] = 0; m_pause[k] = 1;
            end else if (te) begin
                if (m_cook[k]) begin
                    m_cook[k] = 0; m_pause[k] = 1;
                end else begin
                    m_v[k] = 0; m_pause[k] = 0; m_done[k] = 0;
                end
            end else if (tick) begin
                if (m_cook[k]) begin
                    m_v[k] = (m_v[k] % 100 > 0) ? m_v[k] - 1 : m_v[k] - 41;
                    m_phase[k] = (m_phase[k] + 1) % 10;
                    if (m_v[k] == 0) begin
                        m_cook[k] = 0; m_done[k] = 1; m_left[k] = 3;
                    end
                end else begin
                    m_left[k]--;
                    if (m_left[k] == 0) m_done[k] = 0;
                end
            end else if (se) begin
                if (!m_cook[k] && !m_done[k] && door_closed && m_v[k] != 0) begin
                    m_cook[k] = 1; m_pause[k] = 0; m_presc[k] = 0; m_phase[k] = 0;
                end
            end else if (pe) begin
                if (!m_cook[k] && !m_pause[k] && !m_done[k]) m_armed[k] = 1;
            end else if (ke && !m_cook[k] && !m_pause[k]) begin
                m_done[k] = 0;
                if (m_armed[k]) begin
                    m_pwr[k] = (d == 0) ? 10 : d;
                    m_armed[k] = 0;
                end else begin
                    m_v[k] = (m_v[k] * 10 + d) % modv;
                end
            end
            m_mag[k] = m_cook[k] && door_closed && (m_phase[k] < m_pwr[k]);
        end
        p_key = keypad; p_powern = powern; p_startn = startn; p_stopn = stopn;
    endtask

    task automatic compare_model();
        logic [31:0] ea, eb;
        ea = {9'd0, 8'(to_bcd(m_v[0] / 100)), 4'((m_v[0] / 10) % 10), 4'(m_v[0] % 10),
              4'(m_pwr[0]), m_mag[0], m_cook[0], m_done[0]};
        eb = {9'd0, 8'(to_bcd(m_v[1] / 100)), 4'((m_v[1] / 10) % 10), 4'(m_v[1] % 10),
              4'(m_pwr[1]), m_mag[1], m_cook[1], m_done[1]};
        check("model_a", {9'd0, 4'd0, a_min, a_tens, a_ones, a_pwr, a_mag, a_cook, a_done}, ea);
        check("model_b", {9'd0, b_min, b_tens, b_ones, b_pwr, b_mag, b_cook, b_done}, eb);
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        compare_model();
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic press_key(input int d);
        keypad = 10'(1) << d;
        cycle();
        keypad = '0;
        cycle();
    endtask

    // sel: 0 start, 1 stop, 2 power
    task automatic push(input int sel);
        case (sel)
            0: startn = 1'b0;
            1: stopn  = 1'b0;
            default: powern = 1'b0;
        endcase
        cycle();
        startn = 1'b1; stopn = 1'b1; powern = 1'b1;
        cycle();
    endtask

    task automatic random_inputs();
        int r;
        clearn = ($urandom_range(0, 99) >= 2);
        if ($urandom_range(0, 49) == 0) door_closed = ~door_closed;
        startn = ($urandom_range(0, 19) != 0);
        stopn  = ($urandom_range(0, 39) != 0);
        powern = ($urandom_range(0, 29) != 0);
        r = $urandom_range(0, 9);
        if (r == 0)      keypad = 10'(1) << $urandom_range(0, 9);
        else if (r == 1) keypad = (10'(1) << $urandom_range(0, 9)) | (10'(1) << $urandom_range(0, 9));
        else             keypad = '0;
    endtask

    initial begin
        rstn = 1'b0; keypad = '0; powern = 1'b1; startn = 1'b1; stopn = 1'b1;
        clearn = 1'b1; door_closed = 1'b1;
        run(2);
        check("rst_time", {a_min, a_tens, a_ones}, 12'h000);
        check("rst_pwr", a_pwr, 10);
        check("rst_flags", {a_mag, a_cook, a_done}, 3'b000);
        rstn = 1'b1;
        cycle();

        // 1:30 countdown
        press_key(1); press_key(3); press_key(0);
        check("entry_130_a", {a_min, a_tens, a_ones}, 12'h130);
        check("entry_130_b", {b_min, b_tens, b_ones}, 16'h0130);
        push(0);
        check("cook_start", a_cook, 1'b1);
        run(3);
        check("first_tick_129", {a_min, a_tens, a_ones}, 12'h129);
        run(116);
        check("at_100", {a_min, a_tens, a_ones}, 12'h100);
        run(4);
        check("min_borrow_059", {a_min, a_tens, a_ones}, 12'h059);
        run(236);
        check("zero_done", {a_mag, a_cook, a_done}, 3'b001);
        run(12);
        check("done_expired", {a_cook, a_done}, 2'b00);

        // 0:99 countdown
        press_key(9); press_key(9);
        check("entry_099", {a_min, a_tens, a_ones}, 12'h099);
        push(0);
        run(3);
        check("tick_098", {a_min, a_tens, a_ones}, 12'h098);
        run(32);
        check("tens9_090", {a_min, a_tens, a_ones}, 12'h090);
        run(4);
        check("tens9_089", {a_min, a_tens, a_ones}, 12'h089);
        run(356);
        check("zero99_done", {a_mag, a_cook, a_done}, 3'b001);
        run(11);
        check("done_hold3", a_done, 1'b1);
        run(1);
        check("done_end3", a_done, 1'b0);

        // power level 3 duty cycle
        push(2);
        press_key(3);
        check("power_set3", a_pwr, 4'd3);
        press_key(3); press_key(0);
        check("entry_030", {a_min, a_tens, a_ones}, 12'h030);
        push(0);
        check("duty_ph0_on", a_mag, 1'b1);
        run(12);
        check("duty_ph3_off", a_mag, 1'b0);
        run(28);
        check("duty_wrap_on", a_mag, 1'b1);
        run(100);

        // clear restores full power
        clearn = 1'b0; cycle(); clearn = 1'b1; cycle();
        check("clear_pwr10", a_pwr, 4'd10);

        // door open mid-cook
        press_key(1); press_key(5);
        push(0);
        run(31);
        check("door_pre_007", {a_min, a_tens, a_ones}, 12'h007);
        door_closed = 1'b0;
        cycle();
        check("door_open_pause", {a_mag, a_cook}, 2'b00);
        run(10);
        check("door_frozen", {a_cook, a_min, a_tens, a_ones}, 13'h0007);
        door_closed = 1'b1;
        run(10);
        check("door_close_stays", {a_cook, a_min, a_tens, a_ones}, 13'h0007);
        push(0);
        check("resume_cook", a_cook, 1'b1);
        run(3);
        check("resume_006", {a_min, a_tens, a_ones}, 12'h006);

        // stop: pause, then clear
        push(1);
        check("stop_pause", {a_cook, a_min, a_tens, a_ones}, 13'h0006);
        push(1);
        check("stop_clear", {a_cook, a_min, a_tens, a_ones}, 13'h0000);

        // clear during cook
        push(2); press_key(5);
        press_key(2); press_key(0);
        push(0);
        run(6);
        check("cook_before_clr", a_cook, 1'b1);
        clearn = 1'b0;
        cycle();
        check("clr_cook", {a_mag, a_cook, a_pwr}, 6'h0A);
        clearn = 1'b1;
        cycle();

        // two minute digits, zero-time start, multi-key press
        press_key(1); press_key(2); press_key(3); press_key(4); press_key(5);
        check("two_min_2345", {b_min, b_tens, b_ones}, 16'h2345);
        check("one_min_345", {a_min, a_tens, a_ones}, 12'h345);
        push(1);
        check("idle_stop_clr", {b_min, b_tens, b_ones}, 16'h0000);
        push(0);
        check("zero_start_idle", b_cook, 1'b0);
        press_key(5);
        keypad = 10'b0000001100;
        cycle();
        keypad = '0;
        cycle();
        check("multikey_ignored", {b_min, b_tens, b_ones}, 16'h0005);

        // randomized traffic against the model
        door_closed = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            random_inputs();
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
